pulse_stretch: RTL
==================

# pulse_stretch

Output-side timing companion to the switch debouncer. The debouncer rejects input events shorter than a minimum time; this block guarantees every output event lasts at least a minimum time. It turns any rising edge on a one-cycle or short synchronous trigger into a clean pulse of fixed, visible length, followed by an enforced low gap so back-to-back events remain distinguishable. Typical loads are score/hit LEDs and a buzzer enable in the Pong top level, all on the 100 MHz system clock.

## Interface
- TICK_DIV, 1000000, clock cycles per tick (10 ms at 100 MHz); must be ≥ 2
- HOLD_TICKS, 10, ticks the output is held high; must be ≥ 1
- GAP_TICKS, 5, ticks the output is forced low after a hold; must be ≥ 1
- CW, 20, prescaler width; must satisfy 2^CW ≥ TICK_DIV
- TW, 8, tick-counter width; must satisfy 2^TW > max(HOLD_TICKS, GAP_TICKS)

Ports:
- clock  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- trig  in  1  synchronous trigger level; only rising edges matter
- pulse  out  1  stretched output, registered
- busy  out  1  high whenever state ≠ IDLE, registered

## Operation
- Edge detect: trig_d <= trig; rise = trig & ~trig_d. trig_d resets to 0, so trig already high at reset release counts as one rise.
- Prescaler pre counts 0..TICK_DIV-1; tick = (pre == TICK_DIV-1). Tick counter tcnt increments on tick. Both clear to 0 on every state entry and on every retrigger.
- Terminal conditions: HOLD ends when tick & (tcnt == HOLD_TICKS-1); GAP ends when tick & (tcnt == GAP_TICKS-1).
- State machine:
  - IDLE: rise → HOLD; otherwise stay. pre and tcnt are held at 0.
  - HOLD: rise → stay in HOLD with counters cleared (retrigger extends the pulse). Otherwise, on the terminal condition → GAP. Rise wins over a simultaneous terminal.
  - GAP: rise sets pending. On the terminal condition: if pending or rise → HOLD (pending cleared); otherwise → IDLE.
- pending is one bit, so any number of rises during GAP collapse into one deferred pulse. pending is cleared on entry to HOLD.
- Outputs are registered from next state: pulse <= (next_state == HOLD); busy <= (next_state != IDLE).
- Reset values: state IDLE, pulse 0, busy 0, pre 0, tcnt 0, pending 0, trig_d 0. Reset overrides everything, including mid-HOLD and mid-GAP. Pending events are discarded.

## Timing
- Latency: rise visible in cycle k → pulse and busy high from cycle k+1.
- Without a retrigger, pulse is high for exactly HOLD_TICKS·TICK_DIV cycles.
- GAP lasts exactly GAP_TICKS·TICK_DIV cycles with pulse low and busy high.
- A retrigger in HOLD cycle j (1-based) gives a total high time of j + HOLD_TICKS·TICK_DIV cycles.
- A pending pulse starts in the cycle immediately after GAP ends; busy stays high throughout.
- Minimum low time between two pulses is GAP_TICKS·TICK_DIV cycles, so pulse never glitches low for less than that.
- Reset asserted at edge k → pulse and busy are 0 from cycle k+1.

## Test plan
Bench parameters: TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2, giving a 12-cycle hold and 8-cycle gap.
- Single 1-cycle trig → pulse high for exactly 12 cycles starting 1 cycle later; busy high for 20 cycles; then IDLE with pulse=0 and busy=0.
- Second rise seen in HOLD cycle 5 → pulse high for 17 consecutive cycles total, then an 8-cycle gap.
- Rise during GAP cycle 3 → pulse stays low for the full 8 gap cycles, then high for 12 cycles; busy never drops.
- Three rises during one GAP → exactly one additional 12-cycle pulse, then IDLE.
- trig held high for 100 cycles → exactly one 12-cycle pulse. trig high across reset release → exactly one pulse after reset.
- reset asserted in HOLD cycle 6 → pulse=0 and busy=0 the next cycle; no later pulse unless trig rises again. A rise in the terminal HOLD cycle extends the pulse by 12 cycles.

Source files
------------

// File: rtl/pulse_stretch.sv
// Pulse stretcher: turns each rising edge on trig into a fixed-length high pulse
// followed by an enforced low gap, with a single deferred retrigger captured during the gap.
module pulse_stretch #(
  parameter int TICK_DIV   = 1000000,
  parameter int HOLD_TICKS = 10,
  parameter int GAP_TICKS  = 5,
  parameter int CW         = 20,
  parameter int TW         = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic trig,
  output logic pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [CW-1:0]  pre;
  logic [CW-1:0]  pre_next;
  logic [TW-1:0]  tcnt;
  logic [TW-1:0]  tcnt_next;
  logic           pending;
  logic           pending_next;
  logic           trig_d;
  logic           rise;
  logic           tick;
  logic           hold_done;
  logic           gap_done;
  logic           clear_cnt;

  // trig_d resets low so a trigger already high at reset release counts as an edge
  assign rise      = trig & ~trig_d;
  assign tick      = (pre == CW'(TICK_DIV - 1));
  assign hold_done = tick && (tcnt == TW'(HOLD_TICKS - 1));
  assign gap_done  = tick && (tcnt == TW'(GAP_TICKS - 1));

  // Next-state logic; clear_cnt restarts the timebase on every state entry and retrigger
  always_comb begin
    next_state   = state;
    pending_next = pending;
    clear_cnt    = 1'b0;
    case (state)
      IDLE: begin
        clear_cnt    = 1'b1;
        pending_next = 1'b0;
        if (rise) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        pending_next = 1'b0;
        if (rise) begin
          clear_cnt = 1'b1;
        end else if (hold_done) begin
          next_state = GAP;
          clear_cnt  = 1'b1;
        end
      end
      GAP: begin
        pending_next = pending | rise;
        if (gap_done) begin
          clear_cnt = 1'b1;
          if (pending || rise) begin
            next_state   = HOLD;
            pending_next = 1'b0;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state   = IDLE;
        clear_cnt    = 1'b1;
        pending_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    pre_next  = pre + CW'(1);
    tcnt_next = tcnt;
    if (clear_cnt) begin
      pre_next  = '0;
      tcnt_next = '0;
    end else if (tick) begin
      pre_next  = '0;
      tcnt_next = tcnt + TW'(1);
    end
  end

  // Outputs are registered from next_state so they change in the same cycle as the state
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pre     <= '0;
      tcnt    <= '0;
      pending <= 1'b0;
      trig_d  <= 1'b0;
      pulse   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= next_state;
      pre     <= pre_next;
      tcnt    <= tcnt_next;
      pending <= pending_next;
      trig_d  <= trig;
      pulse   <= (next_state == HOLD);
      busy    <= (next_state != IDLE);
    end
  end

endmodule
